// File: rtl/sll32_seq_if.sv
// sll32_seq_if: start/busy/done handshake and data bus of the iterative shifter.
// The dir signal exists only when SLL32_SEQ_SRL_EN is defined.
interface sll32_seq_if;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
`ifdef SLL32_SEQ_SRL_EN
    logic        dir;
`endif
    logic [31:0] res;
    logic        busy;
    logic        done;

`ifdef SLL32_SEQ_SRL_EN
    modport master (output start, A, B, dir, input res, busy, done);
    modport slave  (input start, A, B, dir, output res, busy, done);
`else
    modport master (output start, A, B, input res, busy, done);
    modport slave  (input start, A, B, output res, busy, done);
`endif
endinterface

// File: rtl/sll32_seq.sv
// sll32_seq: multi-cycle 32-bit logical left shifter, STEP bits per cycle, shamt = B[10:6].
// Defining SLL32_SEQ_SRL_EN adds a dir input selecting logical right shift.
module sll32_seq #(
    parameter int STEP = 1
) (
    input logic         clk,
    input logic         rst_n,
    sll32_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] work_q, work_d;
    logic [31:0] res_q, res_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  n;
    logic [4:0]  rem;
    logic [31:0] shifted;
    logic        unused_b;

    assign unused_b = ^{bus.B[31:11], bus.B[5:0]};

    // A zero count yields n=0, so the single mandatory SHIFT visit just copies work to res.
    assign n   = (cnt_q < 5'(STEP)) ? cnt_q : 5'(STEP);
    assign rem = cnt_q - n;

`ifdef SLL32_SEQ_SRL_EN
    logic dir_q, dir_d;
    assign shifted = dir_q ? (work_q >> n) : (work_q << n);
`else
    assign shifted = work_q << n;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
`ifdef SLL32_SEQ_SRL_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
`ifdef SLL32_SEQ_SRL_EN
            dir_q   <= dir_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
`ifdef SLL32_SEQ_SRL_EN
        dir_d   = dir_q;
`endif
        if (state_q == SHIFT) begin
            work_d = shifted;
            cnt_d  = rem;
            if (rem == 5'd0) begin
                res_d   = shifted;
                state_d = DONE;
            end
        end else if (bus.start) begin
            work_d  = bus.A;
            cnt_d   = bus.B[10:6];
`ifdef SLL32_SEQ_SRL_EN
            dir_d   = bus.dir;
`endif
            state_d = SHIFT;
        end else begin
            state_d = IDLE;
        end
    end

    assign bus.res  = res_q;
    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_sll32_seq.sv
// tb_sll32_seq: directed self-checking bench for sll32_seq (STEP=1).
module tb_sll32_seq;
    localparam int STEP = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;

    sll32_seq_if bus ();

    sll32_seq #(.STEP(STEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Launches one operation, then scrambles A/B to prove they were captured at accept.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic d,
                         output logic [31:0] r, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = a;
        bus.B = b;
`ifdef SLL32_SEQ_SRL_EN
        bus.dir = d;
`else
        if (d) $display("note: dir ignored in left-only build");
`endif
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A = ~a;
        bus.B = ~b;
        lat = 1;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = bus.res;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if (bus.res !== 32'h0) $display("FAIL reset_res: got %h want 00000000", bus.res); else passes++;
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passes++;
        checks++;
        if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_shift_basic;
        logic [31:0] r;
        int lat;
        do_op(32'hF0F0F0F0, 32'h00000040, 1'b0, r, lat);
        checks++;
        if (r !== 32'hE1E1E1E0) $display("FAIL sh1_res: got %h want E1E1E1E0", r); else passes++;
        checks++;
        if (lat != 2) $display("FAIL sh1_lat: got %0d want 2", lat); else passes++;
        do_op(32'hF0F0F0F0, 32'h000000C0, 1'b0, r, lat);
        checks++;
        if (r !== 32'h87878780) $display("FAIL sh3_res: got %h want 87878780", r); else passes++;
        checks++;
        if (lat != 4) $display("FAIL sh3_lat: got %0d want 4", lat); else passes++;
        do_op(32'hF0F0F0F0, 32'h000001C0, 1'b0, r, lat);
        checks++;
        if (r !== 32'h78787800) $display("FAIL sh7_res: got %h want 78787800", r); else passes++;
        checks++;
        if (lat != 8) $display("FAIL sh7_lat: got %0d want 8", lat); else passes++;
    endtask

    task automatic test_edges;
        logic [31:0] r;
        int lat;
        do_op(32'h00000001, 32'h000007C0, 1'b0, r, lat);
        checks++;
        if (r !== 32'h80000000) $display("FAIL sh31_res: got %h want 80000000", r); else passes++;
        checks++;
        if (lat != 32) $display("FAIL sh31_lat: got %0d want 32", lat); else passes++;
        do_op(32'hDEADBEEF, 32'hFFFFF83F, 1'b0, r, lat);
        checks++;
        if (r !== 32'hDEADBEEF) $display("FAIL sh0_res: got %h want DEADBEEF", r); else passes++;
        checks++;
        if (lat != 2) $display("FAIL sh0_lat: got %0d want 2", lat); else passes++;
        do_op(32'hFFFFFFFF, 32'h00000400, 1'b0, r, lat);
        checks++;
        if (r !== 32'hFFFF0000) $display("FAIL sh16_res: got %h want FFFF0000", r); else passes++;
    endtask

    task automatic test_busy_ignore;
        int lat;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = 32'hF0F0F0F0;
        bus.B = 32'h000001C0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = 32'hFFFFFFFF;
        bus.B = 32'h0;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (bus.res !== 32'h78787800) $display("FAIL ignore_res: got %h want 78787800", bus.res); else passes++;
        lat = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) lat++;
        end
        checks++;
        if (lat != 0) $display("FAIL ignore_queued: got %0d active cycles want 0", lat); else passes++;
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = 32'h0000000F;
        bus.B = 32'h000000C0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (bus.res !== 32'h00000078) $display("FAIL b2b_first: got %h want 00000078", bus.res); else passes++;
        bus.start = 1'b1;
        bus.A = 32'h00000001;
        bus.B = 32'h00000100;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) $display("FAIL b2b_no_gap: busy got %b want 1", bus.busy); else passes++;
        lat = 1;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (bus.res !== 32'h00000010) $display("FAIL b2b_second: got %h want 00000010", bus.res); else passes++;
        checks++;
        if (lat != 5) $display("FAIL b2b_lat: got %0d want 5", lat); else passes++;
    endtask

`ifdef SLL32_SEQ_SRL_EN
    task automatic test_srl;
        logic [31:0] r;
        int lat;
        do_op(32'hF0F0F0F0, 32'h000001C0, 1'b1, r, lat);
        checks++;
        if (r !== 32'h01E1E1E1) $display("FAIL srl7_res: got %h want 01E1E1E1", r); else passes++;
        checks++;
        if (lat != 8) $display("FAIL srl7_lat: got %0d want 8", lat); else passes++;
    endtask
`endif

    task automatic test_reset_mid;
        int hits;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = 32'h00000001;
        bus.B = 32'h000007C0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", bus.busy); else passes++;
        #2;
        rst_n = 1'b0;
        bus.start = 1'b1;
        #1;
        checks++;
        if (bus.res !== 32'h0) $display("FAIL mid_res: got %h want 00000000", bus.res); else passes++;
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", bus.busy); else passes++;
        checks++;
        if (bus.done !== 1'b0) $display("FAIL mid_done: got %b want 0", bus.done); else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_beats_start: busy got %b want 0", bus.busy); else passes++;
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hits = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) hits++;
        end
        checks++;
        if (hits != 0) $display("FAIL mid_no_done: got %0d done cycles want 0", hits); else passes++;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
`ifdef SLL32_SEQ_SRL_EN
        bus.dir = 1'b0;
`endif
        test_reset;
        test_shift_basic;
        test_edges;
        test_busy_ignore;
        test_back_to_back;
`ifdef SLL32_SEQ_SRL_EN
        test_srl;
`endif
        test_reset_mid;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/sll32_seq.md
Name: sll32_seq

Overview:
- Multi-cycle 32-bit logical left shifter; the left-shift counterpart of the existing combinational srl32 element.
- Takes operand A and instruction word B. The shift amount is B[10:6], the MIPS shamt field.
- Shifts iteratively, STEP bits per cycle, using a start/busy/done handshake.
- Sits beside the ALU elements in the execute stage. A small-area alternative to a full barrel shifter.

Parameters:
- STEP, 1, bits shifted per SHIFT cycle. Legal values: 1, 2, 4, 8.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  request pulse; sampled only when busy=0.
- A  in  32  operand to shift.
- B  in  32  instruction word; shamt = B[10:6]. All other bits are ignored.
- res  out  32  result register. Holds the last result until the next completion.
- busy  out  1  high while the state is SHIFT.
- done  out  1  one-cycle pulse; res is valid in the same cycle.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, res=0, busy=0, done=0. Internal work register and counter are cleared.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=0, done=1.
- Accept: in IDLE or DONE with start=1, capture work=A and cnt=B[10:6] (5 bits, range 0..31), then go to SHIFT.
- start during SHIFT is ignored and not queued.
- SHIFT, each cycle:
  - Let n = min(STEP, cnt).
  - work <= work << n, zero-filled; cnt <= cnt - n.
  - If cnt - n == 0: res <= shifted work, go to DONE.
  - If cnt == 0 on entry: no shift; res <= work; go to DONE. This keeps the SHIFT visit at a minimum of one cycle.
- DONE: lasts one cycle. Goes to IDLE, or to SHIFT if start=1 (back-to-back operation).
- Latency: with k = ceil(shamt/STEP), done rises max(k,1)+1 cycles after the accepting edge.
  - STEP=1, shamt=31: 32 cycles.
  - shamt=0: 2 cycles.
- Width rules:
  - Bits shifted out above bit 31 are discarded.
  - Zero-fill on the right.
  - shamt is at most 31, so the result is never forced to all zeros by the amount alone.
- res changes only on entry to DONE or on reset. A and B may change freely after accept.
- Reset mid-SHIFT: abort immediately to the reset values above. No done pulse.
- Simultaneous start and rst_n=0: reset wins.

Optional Feature:
- Macro SLL32_SEQ_SRL_EN.
- Defined:
  - Adds input port dir (1 bit), captured at accept alongside A and B.
  - dir=1 selects logical right shift: work >> n, zero-fill on the left.
  - dir=0 selects left shift.
  - Timing, handshake and latency are identical in both directions.
- Undefined:
  - Port dir is absent.
  - Left shift only.

Test Plan:
1. Reset check: assert rst_n=0 mid-SHIFT -> res=0, busy=0, done=0 immediately. No done pulse follows after release.
2. STEP=1, A=0xF0F0F0F0, B=0x00000040 (shamt 1) -> done 2 cycles after accept, res=0xE1E1E1E0.
3. STEP=1, A=0xF0F0F0F0, B=0x000000C0 (shamt 3) -> done after 4 cycles, res=0x87878780. Then B=0x000001C0 (shamt 7) -> done after 8 cycles, res=0x78787800.
4. Edge amounts:
   - A=0x00000001, B=0x000007C0 (shamt 31) -> res=0x80000000 after 32 cycles (STEP=1) or 5 cycles (STEP=8).
   - B=0 -> res=A after 2 cycles.
5. Handshake:
   - start pulsed while busy -> ignored; res reflects only the first request.
   - start held in the DONE cycle -> new operation accepted with no IDLE gap.
6. SLL32_SEQ_SRL_EN defined, dir=1, A=0xF0F0F0F0, B=0x000001C0 -> res=0x01E1E1E1. Same latency as the left shift.
